tl_ul_arbiter_2to1: RTL

// Two-master to one-slave arbiter for the 32-bit TileLink-UL crossbar port that
//   the protocol monitors check. Round-robin grant on A; a multi-beat Put burst holds
//   the grant until its last beat. Master index is tagged into the MSB of a_source.
// D responses are routed back by that MSB and the tag is stripped.
// A per-master outstanding counter blocks new A requests once MAX_INFLIGHT is reached.
//

---
 rtl/tl_ul_arbiter_2to1_if.sv | 39 +++
 rtl/tl_ul_arbiter_2to1.sv | 136 +++++++++++++
 2 files changed

// File: rtl/tl_ul_arbiter_2to1_if.sv
// One TileLink-UL link (A request channel + D response channel) on a 32-bit bus.
// The source width is a parameter so the same bundle serves master and slave sides.
interface tl_ul_arbiter_2to1_if #(
  parameter int SRC_W = 4
);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [3:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;

  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [3:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_denied;
  logic [31:0]      d_data;
  logic             d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin A grant with burst lock,
// master index tagged into the slave-side source MSB, D routed back by that tag.
module tl_ul_arbiter_2to1 #(
  parameter int SRC_W        = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int MAX_SIZE     = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  tl_ul_arbiter_2to1_if.slave  m0,
  tl_ul_arbiter_2to1_if.slave  m1,
  tl_ul_arbiter_2to1_if.master s
);
  // Wide enough for 1<<(MAX_SIZE-2) beats; larger illegal sizes simply wrap.
  localparam int               CNT_W     = (MAX_SIZE > 3) ? MAX_SIZE - 1 : 2;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       INF_LIMIT = 4'(MAX_INFLIGHT);
  localparam logic [0:0]       ST_IDLE   = 1'b0;
  localparam logic [0:0]       ST_LOCKED = 1'b1;

  function automatic logic [CNT_W-1:0] beats_of(input logic multi, input logic [3:0] size);
    logic [15:0] b;
    b = (multi && size > 4'd2) ? (16'd1 << (size - 4'd2)) : 16'd1;
    return b[CNT_W-1:0];
  endfunction

  logic [0:0]       lock;
  logic             lock_id;
  logic             last_win;
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] d_cnt;
  logic [1:0][3:0]  inflight;

  logic [1:0]       req_ok;
  logic [1:0]       inc;
  logic [1:0]       dec;
  logic             grant;
  logic             a_valid_g;
  logic             a_fire;
  logic             d_sel;
  logic             d_fire;
  logic             d_last;
  logic [2:0]       a_opcode_g;
  logic [3:0]       a_size_g;
  logic [CNT_W-1:0] a_beats;
  logic [CNT_W-1:0] d_beats;

  always_comb begin
    // Mid-burst the owner keeps the grant and its inflight count is not rechecked.
    if (lock == ST_LOCKED) begin
      req_ok = {m1.a_valid, m0.a_valid};
      grant  = lock_id;
    end else begin
      req_ok[0] = m0.a_valid && (inflight[0] < INF_LIMIT);
      req_ok[1] = m1.a_valid && (inflight[1] < INF_LIMIT);
      grant     = (&req_ok) ? ~last_win : req_ok[1];
    end
    a_valid_g  = !reset && req_ok[grant];
    a_fire     = a_valid_g && s.a_ready;
    a_opcode_g = grant ? m1.a_opcode : m0.a_opcode;
    a_size_g   = grant ? m1.a_size : m0.a_size;
    a_beats    = beats_of(a_opcode_g <= 3'd1, a_size_g);

    d_sel   = s.d_source[SRC_W];
    d_fire  = !reset && s.d_valid && (d_sel ? m1.d_ready : m0.d_ready);
    d_beats = beats_of(s.d_opcode == 3'd1, s.d_size);
    d_last  = (d_cnt == '0) ? (d_beats == CNT_ONE) : (d_cnt == CNT_ONE);

    inc        = '0;
    dec        = '0;
    inc[grant] = a_fire && (lock == ST_IDLE);
    dec[d_sel] = d_fire && d_last;
  end

  assign s.a_valid   = a_valid_g;
  assign s.a_opcode  = a_opcode_g;
  assign s.a_param   = grant ? m1.a_param : m0.a_param;
  assign s.a_size    = a_size_g;
  assign s.a_source  = {grant, (grant ? m1.a_source : m0.a_source)};
  assign s.a_address = grant ? m1.a_address : m0.a_address;
  assign s.a_mask    = grant ? m1.a_mask : m0.a_mask;
  assign s.a_data    = grant ? m1.a_data : m0.a_data;
  assign m0.a_ready  = !reset && s.a_ready && !grant && req_ok[0];
  assign m1.a_ready  = !reset && s.a_ready && grant && req_ok[1];

  // D path is a pure combinational steer on the tag bit.
  assign s.d_ready    = !reset && (d_sel ? m1.d_ready : m0.d_ready);
  assign m0.d_valid   = !reset && s.d_valid && !d_sel;
  assign m1.d_valid   = !reset && s.d_valid && d_sel;
  assign m0.d_opcode  = s.d_opcode;
  assign m1.d_opcode  = s.d_opcode;
  assign m0.d_param   = s.d_param;
  assign m1.d_param   = s.d_param;
  assign m0.d_size    = s.d_size;
  assign m1.d_size    = s.d_size;
  assign m0.d_source  = s.d_source[SRC_W-1:0];
  assign m1.d_source  = s.d_source[SRC_W-1:0];
  assign m0.d_denied  = s.d_denied;
  assign m1.d_denied  = s.d_denied;
  assign m0.d_data    = s.d_data;
  assign m1.d_data    = s.d_data;
  assign m0.d_corrupt = s.d_corrupt;
  assign m1.d_corrupt = s.d_corrupt;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock     <= ST_IDLE;
      lock_id  <= 1'b0;
      last_win <= 1'b1;
      a_cnt    <= '0;
      d_cnt    <= '0;
      inflight <= '0;
    end else begin
      if (a_fire) begin
        if (lock == ST_IDLE) begin
          last_win <= grant;
          if (a_beats != CNT_ONE) begin
            lock    <= ST_LOCKED;
            lock_id <= grant;
            a_cnt   <= a_beats - CNT_ONE;
          end
        end else begin
          a_cnt <= a_cnt - CNT_ONE;
          if (a_cnt == CNT_ONE) lock <= ST_IDLE;
        end
      end
      if (d_fire) begin
        if (d_last)           d_cnt <= '0;
        else if (d_cnt == '0) d_cnt <= d_beats - CNT_ONE;
        else                  d_cnt <= d_cnt - CNT_ONE;
      end
      for (int n = 0; n < 2; n++)
        inflight[n] <= inflight[n] + 4'(inc[n]) - 4'(dec[n]);
    end
  end
endmodule
